// File: rtl/memory_block_controller.sv
// Block-request sequencer in front of a single-port embedded memory: turns one
// cache block read/write into N word accesses, with optional injected latency.
module memory_block_controller #(
  parameter  int N_ENTRIES     = 1024,
  parameter  int BW_DATA       = 32,
  parameter  int N_WORDS_BLOCK = 4,
  parameter  int LATENCY       = 0,
  localparam int BW_ADDR       = $clog2(N_ENTRIES),
  localparam int BW_WORD       = $clog2(N_WORDS_BLOCK),
  localparam int BW_BLOCK      = BW_ADDR - BW_WORD
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               req_i,
  input  logic                               req_rw_i,
  input  logic [BW_BLOCK-1:0]                req_addr_i,
  input  logic [BW_DATA*N_WORDS_BLOCK-1:0]   data_block_i,
  output logic                               ready_o,
  output logic                               done_o,
  output logic [BW_DATA*N_WORDS_BLOCK-1:0]   data_block_o,
  output logic                               mem_wren_o,
  output logic [BW_ADDR-1:0]                 mem_addr_o,
  output logic [BW_DATA-1:0]                 mem_data_o,
  input  logic [BW_DATA-1:0]                 mem_data_i
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    CAPTURE,
    DONE
  } state_t;

  state_t                                  state_q;
  state_t                                  state_d;
  logic [7:0]                              wait_q;
  logic [BW_WORD-1:0]                      word_q;
  logic [BW_WORD-1:0]                      word_nxt;
  logic [BW_WORD-1:0]                      word_prev;
  logic                                    rw_q;
  logic [BW_BLOCK-1:0]                     blk_q;
  logic [N_WORDS_BLOCK-1:0][BW_DATA-1:0]   wr_in;
  logic [N_WORDS_BLOCK-1:0][BW_DATA-1:0]   wr_q;
  logic [N_WORDS_BLOCK-1:0][BW_DATA-1:0]   rd_q;
  logic                                    last_word;

  assign wr_in        = data_block_i;
  assign data_block_o = rd_q;
  assign word_nxt     = word_q + BW_WORD'(1);
  assign word_prev    = word_q - BW_WORD'(1);
  assign last_word    = &word_q;

  always_comb begin
    state_d    = state_q;
    ready_o    = 1'b0;
    done_o     = 1'b0;
    mem_wren_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (req_i) state_d = (LATENCY > 0) ? WAIT : ACCESS;
      end
      WAIT: begin
        if (wait_q == '0) state_d = ACCESS;
      end
      ACCESS: begin
        mem_wren_o = rw_q;
        if (last_word) state_d = rw_q ? DONE : CAPTURE;
      end
      CAPTURE: state_d = DONE;
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/data registers are loaded one edge ahead so that the word for
  // cycle w is already on the memory port during ACCESS cycle w.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      word_q     <= '0;
      rw_q       <= 1'b0;
      blk_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            rw_q   <= req_rw_i;
            blk_q  <= req_addr_i;
            word_q <= '0;
            if (req_rw_i) wr_q <= wr_in;
            wait_q <= (LATENCY > 0) ? 8'(LATENCY - 1) : '0;
            if (LATENCY == 0) begin
              mem_addr_o <= {req_addr_i, BW_WORD'(0)};
              if (req_rw_i) mem_data_o <= wr_in[0];
            end
          end
        end
        WAIT: begin
          if (wait_q == '0) begin
            mem_addr_o <= {blk_q, BW_WORD'(0)};
            if (rw_q) mem_data_o <= wr_q[0];
          end else begin
            wait_q <= wait_q - 8'd1;
          end
        end
        ACCESS: begin
          // Read data lags the address by one edge, so word w-1 lands now.
          if (!rw_q && word_q != '0) rd_q[word_prev] <= mem_data_i;
          if (!last_word) begin
            word_q     <= word_nxt;
            mem_addr_o <= {blk_q, word_nxt};
            if (rw_q) mem_data_o <= wr_q[word_nxt];
          end else begin
            word_q <= '0;
          end
        end
        CAPTURE: rd_q[BW_WORD'(N_WORDS_BLOCK - 1)] <= mem_data_i;
        default: ;
      endcase
    end
  end

endmodule
